uart_rx: RTL and testbench

- UART receive stage, directly downstream of the team's baud-rate tick generator.
- Consumes the 16x-oversampling s_tick and deserialises the asynchronous rx line (8N1 by default, LSB first).
- Presents each received byte on dout with a one-cycle rx_done_tick strobe and a framing-error flag.
- Feeds the RX FIFO or the host interface.

---
 rtl/uart_rx_pkg.sv | 16 +
 rtl/uart_rx_if.sv | 26 ++
 rtl/uart_rx_sync_2ff.sv | 21 ++
 rtl/uart_rx.sv | 94 +++++++++
 tb/tb_uart_rx.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM encodings, oversampling constants and counter widths.
package uart_rx_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      START = 2'b01,
      DATA  = 2'b10,
      STOP  = 2'b11
   } uart_state_t;

   localparam int unsigned OVERSAMPLE = 16;
   localparam int unsigned MID_SAMPLE = 7;
   localparam int unsigned S_CNT_W    = 5;
   localparam int unsigned N_W        = 4;

endpackage

// File: rtl/uart_rx_if.sv
// Serial-side inputs and received-word outputs of the UART receiver.
interface uart_rx_if #(
   parameter int unsigned DBIT = 8
);
   logic            rx;
   logic            s_tick;
   logic [DBIT-1:0] dout;
   logic            rx_done_tick;
   logic            frame_err;

   modport master (
      input  rx,
      input  s_tick,
      output dout,
      output rx_done_tick,
      output frame_err
   );

   modport slave (
      output rx,
      output s_tick,
      input  dout,
      input  rx_done_tick,
      input  frame_err
   );
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to RST_VAL.
module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampled, LSB-first deserialiser with framing-error flag.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int unsigned DBIT    = 8,
   parameter int unsigned SB_TICK = 16
) (
   input logic       clk,
   input logic       rst,
   uart_rx_if.master bus
);
   uart_state_t          state;
   logic [S_CNT_W-1:0]   s_cnt;
   logic [N_W-1:0]       n;
   logic [DBIT-1:0]      shift;
   logic                 rx_s;
   logic                 rx_prev;

   sync_2ff #(.RST_VAL(1'b1)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (bus.rx),
      .q   (rx_s)
   );

   // Receive FSM; outputs update only on the stop-bit sample.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         s_cnt            <= '0;
         n                <= '0;
         shift            <= '0;
         rx_prev          <= 1'b1;
         bus.dout         <= '0;
         bus.rx_done_tick <= 1'b0;
         bus.frame_err    <= 1'b0;
      end else begin
         rx_prev          <= rx_s;
         bus.rx_done_tick <= 1'b0;
         case (state)
            IDLE: begin
               // Edge-triggered so a line held low cannot re-arm the receiver.
               if (rx_prev && !rx_s) begin
                  state <= START;
                  s_cnt <= '0;
               end
            end
            START: begin
               if (bus.s_tick) begin
                  if (s_cnt == S_CNT_W'(MID_SAMPLE)) begin
                     if (!rx_s) begin
                        state <= DATA;
                        s_cnt <= '0;
                        n     <= '0;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     s_cnt <= s_cnt + S_CNT_W'(1);
                  end
               end
            end
            DATA: begin
               if (bus.s_tick) begin
                  if (s_cnt == S_CNT_W'(OVERSAMPLE - 1)) begin
                     s_cnt <= '0;
                     shift <= {rx_s, shift[DBIT-1:1]};
                     if (n == N_W'(DBIT - 1)) begin
                        state <= STOP;
                     end else begin
                        n <= n + N_W'(1);
                     end
                  end else begin
                     s_cnt <= s_cnt + S_CNT_W'(1);
                  end
               end
            end
            STOP: begin
               if (bus.s_tick) begin
                  if (s_cnt == S_CNT_W'(SB_TICK - 1)) begin
                     bus.dout         <= shift;
                     bus.frame_err    <= ~rx_s;
                     bus.rx_done_tick <= 1'b1;
                     state            <= IDLE;
                  end else begin
                     s_cnt <= s_cnt + S_CNT_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames, glitch, break, reset abort and tick stall.
module tb_uart_rx;
   import uart_rx_pkg::*;

   typedef struct {
      logic [7:0] d;
      logic       fe;
   } exp_t;

   logic clk;
   logic rst;
   logic tick_en;
   int   tick_cnt;
   int   n_checks;
   int   n_pass;
   exp_t exp_q[$];

   uart_rx_if #(.DBIT(8)) bus ();

   uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // s_tick every 4th clk, driven away from the active edge.
   initial begin
      tick_cnt   = 0;
      bus.s_tick = 1'b0;
      forever begin
         @(negedge clk);
         tick_cnt   = tick_cnt + 1;
         bus.s_tick = tick_en && (tick_cnt % 4 == 0);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks = n_checks + 1;
      if (act === req) n_pass = n_pass + 1;
      else $display("FAIL %s: got %0h, expected %0h", name, act, req);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] d, input logic stop);
      for (int i = 0; i < 8; i++) begin
         bus.rx = d[i];
         wait_clk(64);
      end
      bus.rx = stop;
      wait_clk(64);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop);
      bus.rx = 1'b0;
      wait_clk(64);
      send_bits(d, stop);
   endtask

   task automatic expect_word(input logic [7:0] d, input logic fe);
      exp_t e;
      e.d  = d;
      e.fe = fe;
      exp_q.push_back(e);
   endtask

   // Monitor: every strobe must match the head of the scoreboard.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (bus.rx_done_tick === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {24'h0, bus.dout}, 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               check("dout", {24'h0, bus.dout}, {24'h0, e.d});
               check("frame_err", {31'h0, bus.frame_err}, {31'h0, e.fe});
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, %0d checks done", n_checks);
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_pass   = 0;
      tick_en  = 1'b1;
      rst      = 1'b1;
      bus.rx   = 1'b1;
      wait_clk(5);
      check("reset_dout", {24'h0, bus.dout}, 32'h0);
      check("reset_done", {31'h0, bus.rx_done_tick}, 32'h0);
      check("reset_ferr", {31'h0, bus.frame_err}, 32'h0);
      rst = 1'b0;
      wait_clk(20);

      // Plain frame
      expect_word(8'hA5, 1'b0);
      send_frame(8'hA5, 1'b1);
      wait_clk(64);

      // Start-bit glitch is rejected, then a valid frame
      bus.rx = 1'b0;
      wait_clk(12);
      bus.rx = 1'b1;
      wait_clk(64);
      expect_word(8'h3C, 1'b0);
      send_frame(8'h3C, 1'b1);
      wait_clk(64);

      // Break: 20 bit times low gives one framing-error word
      expect_word(8'h00, 1'b1);
      bus.rx = 1'b0;
      wait_clk(20 * 64);
      bus.rx = 1'b1;
      wait_clk(2 * 64);
      expect_word(8'h7E, 1'b0);
      send_frame(8'h7E, 1'b1);

      // Back-to-back with zero idle gap
      expect_word(8'h55, 1'b0);
      send_frame(8'h55, 1'b1);
      expect_word(8'hAA, 1'b0);
      send_frame(8'hAA, 1'b1);
      wait_clk(64);

      // Reset in the middle of data bit 4 of 0xFF
      bus.rx = 1'b0;
      wait_clk(64);
      bus.rx = 1'b1;
      wait_clk(4 * 64 + 32);
      rst = 1'b1;
      wait_clk(2);
      check("midrst_dout", {24'h0, bus.dout}, 32'h0);
      check("midrst_done", {31'h0, bus.rx_done_tick}, 32'h0);
      check("midrst_ferr", {31'h0, bus.frame_err}, 32'h0);
      wait_clk(4);
      rst = 1'b0;
      wait_clk(26 + 3 * 64 + 64);
      expect_word(8'h81, 1'b0);
      send_frame(8'h81, 1'b1);
      wait_clk(64);

      // Tick stall after a start edge, then resume
      tick_en = 1'b0;
      bus.rx  = 1'b0;
      wait_clk(500);
      check("stall_state", {30'h0, dut.state}, {30'h0, START});
      tick_en = 1'b1;
      wait_clk(64);
      expect_word(8'hC3, 1'b0);
      send_bits(8'hC3, 1'b1);
      wait_clk(128);

      check("queue_drained", exp_q.size(), 32'h0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
